servant_uart_rx: RTL and testbench

SERVANT_UART_RX -- requirements
Module: servant_uart_rx

---
 rtl/servant_uart_rx.sv | 111 +++++++++++
 tb/tb_servant_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver for the servant SoC: 2-flop synchronizer, mid-bit sampling
// FSM, one-deep output register with valid/ready handshake and error pulses.
module servant_uart_rx #(
  parameter int unsigned DIV = 556
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_vld,
  input  logic       i_rdy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(DIV - 1);

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic [1:0]  settle;
  logic        fresh;

  // The synchronizer resets to idle-high, so rx_s is only trusted once the
  // line value has propagated; the first trusted look in IDLE decides
  // whether a line held low through reset must be waited out in BREAK.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      settle      <= '0;
      fresh       <= 1'b1;
      o_data      <= '0;
      o_vld       <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      rx_meta     <= i_rx;
      rx_s        <= rx_meta;
      settle      <= {settle[0], 1'b1};
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_vld && i_rdy) o_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (settle[1]) begin
            fresh <= 1'b0;
            if (!rx_s) begin
              cnt   <= '0;
              state <= fresh ? BREAK : START;
            end
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!o_vld || i_rdy) begin
                o_data <= shreg;
                o_vld  <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_uart_rx.sv
// Scoreboard bench for servant_uart_rx: stimulus pushes expected bytes and
// error counts, an independent monitor pops on every valid/ready transfer.
module tb_servant_uart_rx;
  localparam int unsigned DIV = 16;

  logic       wb_clk   = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       i_rx     = 1'b1;
  logic       i_rdy    = 1'b0;
  logic [7:0] o_data;
  logic       o_vld;
  logic       o_frame_err;
  logic       o_overrun;

  always #5 wb_clk = ~wb_clk;

  servant_uart_rx #(.DIV(DIV)) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_vld       (o_vld),
    .i_rdy       (i_rdy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
  int vld_cycles = 0;
  longint rise_time = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  // Drives one 8N1 frame starting at the current negedge; the line is left at
  // the stop-bit level so a bad stop bit can be stretched by the caller.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      idle(DIV);
    end
    i_rx = stop;
    idle(DIV);
  endtask

  // Monitor: samples 2 time units after each negedge, away from posedge.
  logic [7:0] prev_data;
  logic prev_hold = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0, prev_vld = 1'b0;
  initial begin
    forever begin
      @(negedge wb_clk);
      #2;
      if (!wb_rst_n) begin
        prev_hold = 1'b0; prev_fe = 1'b0; prev_ov = 1'b0; prev_vld = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check("hold_vld", o_vld, 1);
        check("hold_data", o_data, prev_data);
      end
      if (o_frame_err) begin
        fe_seen++;
        check("frame_err_single", prev_fe, 0);
      end
      if (o_overrun) begin
        ov_seen++;
        check("overrun_single", prev_ov, 0);
      end
      if (o_vld) vld_cycles++;
      if (o_vld && !prev_vld) rise_time = longint'($time);
      if (o_vld && i_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h, expected none", o_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("rx_byte", o_data, e);
        end
      end
      prev_hold = o_vld && !i_rdy;
      prev_data = o_data;
      prev_fe   = o_frame_err;
      prev_ov   = o_overrun;
      prev_vld  = o_vld;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint t0;
    int lat;
    int vc0, fe0, ov0;
    logic [7:0] b;

    // Reset state
    idle(3);
    #3;
    check("rst_data", o_data, 8'h00);
    check("rst_vld", o_vld, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_overrun", o_overrun, 0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    idle(5);

    // Single byte, consumer always ready
    i_rdy = 1'b1;
    exp_q.push_back(8'h55);
    vc0 = vld_cycles;
    t0 = longint'($time);
    send_frame(8'h55, 1'b1);
    idle(2);
    #3;
    lat = int'((rise_time - t0 - 2) / 10);
    check("latency_55_in_window", (lat >= 150 && lat <= 175) ? 1 : 0, 1);
    check("vld_one_cycle", vld_cycles - vc0, 1);
    check("vld_cleared", o_vld, 0);
    check("q_empty_55", exp_q.size(), 0);
    if (lat < 20 || lat > 400) lat = 155;

    // Glitch on the line aborts in START
    @(negedge wb_clk);
    vc0 = vld_cycles;
    i_rx = 1'b0;
    idle(4);
    i_rx = 1'b1;
    idle(3 * DIV);
    #3;
    check("glitch_no_vld", vld_cycles - vc0, 0);
    @(negedge wb_clk);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    idle(4);
    #3;
    check("q_empty_a3", exp_q.size(), 0);

    // Bad stop bit, line held low, then recovery
    @(negedge wb_clk);
    fe0 = fe_seen;
    vc0 = vld_cycles;
    send_frame(8'hFF, 1'b0);
    idle(50);
    i_rx = 1'b1;
    fe_exp++;
    idle(2 * DIV);
    #3;
    check("frame_err_pulse", fe_seen - fe0, 1);
    check("frame_err_no_vld", vld_cycles - vc0, 0);
    @(negedge wb_clk);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(4);
    #3;
    check("q_empty_3c", exp_q.size(), 0);

    // Back-to-back frames with a stalled consumer
    @(negedge wb_clk);
    i_rdy = 1'b0;
    ov0 = ov_seen;
    exp_q.push_back(8'h12);
    ov_exp++;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(4);
    #3;
    check("ovr_vld_held", o_vld, 1);
    check("ovr_data_kept", o_data, 8'h12);
    check("ovr_pulse", ov_seen - ov0, 1);
    @(negedge wb_clk);
    i_rdy = 1'b1;
    @(negedge wb_clk);
    i_rdy = 1'b0;
    #3;
    check("ovr_vld_cleared", o_vld, 0);
    check("q_empty_12", exp_q.size(), 0);

    // Reset in the middle of a frame while the line is low
    @(negedge wb_clk);
    i_rdy = 1'b1;
    vc0 = vld_cycles;
    fork
      send_frame(8'h81, 1'b1);
      begin
        idle(40);
        wb_rst_n = 1'b0;
        idle(1);
        #3;
        check("midrst_data", o_data, 8'h00);
        check("midrst_vld", o_vld, 0);
        check("midrst_frame_err", o_frame_err, 0);
        check("midrst_overrun", o_overrun, 0);
        idle(2);
        wb_rst_n = 1'b1;
      end
    join
    idle(4 * DIV);
    #3;
    check("midrst_no_byte", vld_cycles - vc0, 0);
    @(negedge wb_clk);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(4);
    #3;
    check("q_empty_7e", exp_q.size(), 0);

    // Transfer of a held byte coincides with completion of the next one
    @(negedge wb_clk);
    i_rdy = 1'b0;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    idle(2);
    #3;
    check("hold_99_vld", o_vld, 1);
    check("hold_99_data", o_data, 8'h99);
    @(negedge wb_clk);
    ov0 = ov_seen;
    exp_q.push_back(8'hC3);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        idle(lat - 1);
        i_rdy = 1'b1;
        idle(1);
        i_rdy = 1'b0;
      end
    join
    #3;
    check("coincide_vld", o_vld, 1);
    check("coincide_data", o_data, 8'hC3);
    check("coincide_no_overrun", ov_seen - ov0, 0);
    check("coincide_q_one", exp_q.size(), 1);
    @(negedge wb_clk);
    i_rdy = 1'b1;
    idle(3);
    #3;
    check("q_empty_c3", exp_q.size(), 0);

    // Random frames, gaps and glitches with a ready consumer
    @(negedge wb_clk);
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_rx = 1'b0;
        idle($urandom_range(1, 4));
        i_rx = 1'b1;
        idle(2 * DIV);
      end
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      idle($urandom_range(0, 2 * DIV));
    end

    // Random frames with a slow consumer that accepts before the next frame
    for (int n = 0; n < 8; n++) begin
      i_rdy = 1'b0;
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      idle($urandom_range(1, 40));
      i_rdy = 1'b1;
      idle(1);
    end
    i_rdy = 1'b1;
    idle(20);
    #3;
    check("final_q_empty", exp_q.size(), 0);
    check("final_frame_err_count", fe_seen, fe_exp);
    check("final_overrun_count", ov_seen, ov_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
